// File: rtl/adc_pkg.sv
// adc_pkg
//   Shared types and helpers for the serial ADC capture block.
//   - adc_state_t : conversion sequencer states
//   - ADC_FRAME_BITS / ADC_DATA_BITS : default frame geometry (AD7476-class)
//   - adc_field() : extracts one channel's sample field from a captured frame
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    QUIET = 2'd2
  } adc_state_t;

  localparam int unsigned ADC_FRAME_BITS = 16;
  localparam int unsigned ADC_DATA_BITS  = 12;

  // Keeps the last data_bits bits of a frame (leading bits are the converter's
  // zero/pad bits). When signed_out is set the field's MSB is inverted, turning
  // offset binary into two's complement.
  function automatic logic [31:0] adc_field(input logic [31:0] frame,
                                            input int unsigned data_bits,
                                            input logic        signed_out);
    logic [31:0] mask;
    logic [31:0] f;
    mask = (data_bits >= 32) ? '1 : ((32'd1 << data_bits) - 32'd1);
    f    = frame & mask;
    if (signed_out) f = f ^ (32'd1 << (data_bits - 1));
    return f;
  endfunction

endpackage

// File: rtl/adc_clk_div.sv
// adc_clk_div
//   Timing strobes for the ADC capture sequencer.
//   Ports:
//     clk_nexys  in   system clock
//     reset      in   asynchronous, active-low
//     enable     in   sample-rate counter runs while high, held at 0 otherwise
//     run        in   SCLK divider runs while high (frame in progress)
//     tick       out  one-cycle pulse on the cycle the sample counter wraps
//     sclk_fall  out  SCLK should go low at the next edge
//     sclk_rise  out  SCLK should go high at the next edge
module adc_clk_div #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned SAMPLE_DIV = 2268
) (
  input  logic clk_nexys,
  input  logic reset,
  input  logic enable,
  input  logic run,
  output logic tick,
  output logic sclk_fall,
  output logic sclk_rise
);

  localparam int unsigned SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [SW-1:0] SMP_LAST = SW'(SAMPLE_DIV - 1);
  localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);

  logic [SW-1:0] smp_cnt_q, smp_cnt_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          phase_q, phase_d;
  logic          div_tc;

  always_comb begin
    tick = enable && (smp_cnt_q == SMP_LAST);
    if (!enable || tick) smp_cnt_d = '0;
    else                 smp_cnt_d = smp_cnt_q + SW'(1);

    // Half-period down-counter; phase 0 means the next toggle is a fall,
    // so every frame starts with a falling edge from the idle-high level.
    div_tc    = (div_cnt_q == '0);
    div_cnt_d = div_cnt_q;
    phase_d   = phase_q;
    if (!run) begin
      div_cnt_d = DIV_LOAD;
      phase_d   = 1'b0;
    end else if (div_tc) begin
      div_cnt_d = DIV_LOAD;
      phase_d   = ~phase_q;
    end else begin
      div_cnt_d = div_cnt_q - DW'(1);
    end
    sclk_fall = run && div_tc && !phase_q;
    sclk_rise = run && div_tc &&  phase_q;
  end

  always_ff @(posedge clk_nexys or negedge reset) begin
    if (!reset) begin
      smp_cnt_q <= '0;
      div_cnt_q <= DIV_LOAD;
      phase_q   <= 1'b0;
    end else begin
      smp_cnt_q <= smp_cnt_d;
      div_cnt_q <= div_cnt_d;
      phase_q   <= phase_d;
    end
  end

endmodule

// File: rtl/adc_spi_capture.sv
// adc_spi_capture
//   Multi-channel serial ADC capture: frames CS/SCLK at a fixed sample rate,
//   shifts all sdata lines in parallel and offers one aligned sample word on a
//   valid/ready handshake. A frame finishing while the previous word is still
//   pending and not being taken is dropped and flagged on the sticky overrun.
//   Build option: define ADC_SIGNED_OUT_EN to emit two's complement fields
//   (MSB of each field inverted); undefined gives raw unsigned codes.
//   Ports:
//     clk_nexys in  system clock          reset   in  async, active-low
//     enable    in  start conversions     sdata   in  [CHANNELS] serial data
//     SCLK      out serial clock          CS      out chip select, active-low
//     d_out     out sample word           valid   out d_out unconsumed
//     ready     in  consumer accepts      overrun out sticky drop flag
//
//   state | meaning
//   IDLE  | CS high, waiting for a sample tick
//   SHIFT | CS low, SCLK running, capturing FRAME_BITS bits
//   QUIET | CS high guard time; first cycle delivers the captured word
module adc_spi_capture
  import adc_pkg::*;
#(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned FRAME_BITS = ADC_FRAME_BITS,
  parameter int unsigned DATA_BITS  = ADC_DATA_BITS,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned SAMPLE_DIV = 2268,
  parameter int unsigned QUIET_CYC  = 3
) (
  input  logic                          clk_nexys,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [CHANNELS-1:0]           sdata,
  output logic                          SCLK,
  output logic                          CS,
  output logic [CHANNELS*DATA_BITS-1:0] d_out,
  output logic                          valid,
  input  logic                          ready,
  output logic                          overrun
);

`ifdef ADC_SIGNED_OUT_EN
  localparam logic SIGNED_OUT = 1'b1;
`else
  localparam logic SIGNED_OUT = 1'b0;
`endif

  localparam int unsigned BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int unsigned QW = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;

  if ((SAMPLE_DIV < 2*CLK_DIV*FRAME_BITS + QUIET_CYC + 2) ||
      (CHANNELS < 1) || (CHANNELS > 8) || (CLK_DIV < 1) || (QUIET_CYC < 1) ||
      (FRAME_BITS < 2) || (FRAME_BITS > 32) || (DATA_BITS < 1) ||
      (DATA_BITS > FRAME_BITS)) begin : g_bad_params
    $error("adc_spi_capture: parameter set violates frame/rate constraints");
  end

  logic tick, sclk_fall, sclk_rise;

  adc_state_t                    state_q;
  logic [FRAME_BITS-1:0]         shreg_q [CHANNELS];
  logic [BW-1:0]                 bit_cnt_q;
  logic [QW-1:0]                 quiet_cnt_q;
  logic                          done_q;
  logic                          sclk_q, cs_q, valid_q, overrun_q;
  logic [CHANNELS*DATA_BITS-1:0] dout_q;
  logic [CHANNELS*DATA_BITS-1:0] sample_d;

  adc_clk_div #(
    .CLK_DIV    (CLK_DIV),
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_clk_div (
    .clk_nexys (clk_nexys),
    .reset     (reset),
    .enable    (enable),
    .run       (state_q == SHIFT),
    .tick      (tick),
    .sclk_fall (sclk_fall),
    .sclk_rise (sclk_rise)
  );

  always_comb begin
    sample_d = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sample_d[k*DATA_BITS +: DATA_BITS] =
        DATA_BITS'(adc_field(32'(shreg_q[k]), DATA_BITS, SIGNED_OUT));
    end
  end

  always_ff @(posedge clk_nexys or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      quiet_cnt_q <= '0;
      done_q      <= 1'b0;
      sclk_q      <= 1'b1;
      cs_q        <= 1'b1;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      dout_q      <= '0;
      for (int k = 0; k < CHANNELS; k++) shreg_q[k] <= '0;
    end else begin
      if (valid_q && ready) valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (tick) begin
            state_q   <= SHIFT;
            cs_q      <= 1'b0;
            bit_cnt_q <= BW'(FRAME_BITS - 1);
          end
        end
        SHIFT: begin
          if (sclk_fall) sclk_q <= 1'b0;
          if (sclk_rise) begin
            sclk_q <= 1'b1;
            for (int k = 0; k < CHANNELS; k++)
              shreg_q[k] <= {shreg_q[k][FRAME_BITS-2:0], sdata[k]};
            if (bit_cnt_q == '0) begin
              state_q     <= QUIET;
              done_q      <= 1'b1;
              quiet_cnt_q <= QW'(QUIET_CYC - 1);
            end else begin
              bit_cnt_q <= bit_cnt_q - BW'(1);
            end
          end
        end
        QUIET: begin
          // Delivery sits one cycle after the last rising edge so the final
          // bit is already in the shift registers. A load here overrides the
          // handshake clear above, keeping valid high on a same-cycle accept.
          if (done_q) begin
            done_q <= 1'b0;
            cs_q   <= 1'b1;
            if (!valid_q || ready) begin
              dout_q  <= sample_d;
              valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end
          if (quiet_cnt_q == '0) state_q <= IDLE;
          else                   quiet_cnt_q <= quiet_cnt_q - QW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign SCLK    = sclk_q;
  assign CS      = cs_q;
  assign d_out   = dout_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_adc_spi_capture.sv
module tb_adc_spi_capture;

  localparam int CH   = 2;
  localparam int FB   = 16;
  localparam int DB   = 12;
  localparam int CKD  = 2;
  localparam int SDIV = 100;
  localparam int QC   = 3;
  localparam int CS_LOW = 2*CKD*FB + 1;

`ifdef ADC_SIGNED_OUT_EN
  localparam logic [23:0] EXP_BASIC = 24'h9232BC;
`else
  localparam logic [23:0] EXP_BASIC = 24'h123ABC;
`endif

  logic           clk_nexys = 1'b0;
  logic           reset;
  logic           enable;
  logic           ready;
  logic [CH-1:0]  sdata;
  logic           SCLK;
  logic           CS;
  logic [CH*DB-1:0] d_out;
  logic           valid;
  logic           overrun;

  int checks = 0;
  int errors = 0;

  logic [15:0] fix_frm [CH];
  bit          use_fixed = 1'b0;
  logic [23:0] cur_exp = '0;

  adc_spi_capture #(
    .CHANNELS   (CH),
    .FRAME_BITS (FB),
    .DATA_BITS  (DB),
    .CLK_DIV    (CKD),
    .SAMPLE_DIV (SDIV),
    .QUIET_CYC  (QC)
  ) dut (
    .clk_nexys (clk_nexys),
    .reset     (reset),
    .enable    (enable),
    .sdata     (sdata),
    .SCLK      (SCLK),
    .CS        (CS),
    .d_out     (d_out),
    .valid     (valid),
    .ready     (ready),
    .overrun   (overrun)
  );

  initial forever #5 clk_nexys = ~clk_nexys;

  // Sample word the converters' frames should produce: low 12 bits of each
  // 16-bit frame, channel 0 in the low field.
  function automatic logic [23:0] model_word(input logic [15:0] f0, input logic [15:0] f1);
    logic [23:0] w;
    w = {f1[11:0], f0[11:0]};
`ifdef ADC_SIGNED_OUT_EN
    w = w ^ 24'h800800;
`endif
    return w;
  endfunction

  // ADC model: frame chosen at CS fall, one bit (MSB first) presented after
  // each SCLK falling edge; a CS rise aborts the frame.
  initial begin
    logic [15:0] frm [CH];
    int idx;
    sdata = '0;
    forever begin
      @(negedge CS);
      for (int c = 0; c < CH; c++) frm[c] = use_fixed ? fix_frm[c] : 16'($urandom);
      cur_exp = model_word(frm[0], frm[1]);
      idx = FB;
      forever begin
        @(negedge SCLK or posedge CS);
        if (CS === 1'b1) break;
        if (idx > 0) idx--;
        for (int c = 0; c < CH; c++) sdata[c] = frm[c][idx];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (on falling clock edges) until CS or valid reaches lvl.
  task automatic wait_for(input bit sel_valid, input logic lvl, input int max,
                          input string tag, output int n);
    n = 0;
    while (((sel_valid ? valid : CS) !== lvl) && n < max) begin
      @(negedge clk_nexys);
      n++;
    end
    if ((sel_valid ? valid : CS) !== lvl)
      chk({tag, "_timeout"}, 64'(sel_valid ? valid : CS), 64'(lvl));
  endtask

  task automatic wait_cs_fall(input string tag);
    int n;
    wait_for(1'b0, 1'b1, SDIV + 10, tag, n);
    wait_for(1'b0, 1'b0, SDIV + 10, tag, n);
  endtask

  initial begin
    int n, falls, sclk_bad, last_fall, low_cnt, rises, bad, first;
    logic prev_cs, prev_sclk;
    logic [23:0] held;

    reset = 1'b0; enable = 1'b0; ready = 1'b1;
    fix_frm[0] = 16'h0ABC; fix_frm[1] = 16'h0123;
    #1;
    repeat (3) @(negedge clk_nexys);
    chk("rst_sclk", 64'(SCLK), 64'(1'b1));
    chk("rst_cs", 64'(CS), 64'(1'b1));
    chk("rst_dout", 64'(d_out), 64'(0));
    chk("rst_valid", 64'(valid), 64'(1'b0));
    chk("rst_overrun", 64'(overrun), 64'(1'b0));

    // Disabled: no conversion activity
    reset = 1'b1;
    bad = 0;
    repeat (150) begin
      @(negedge clk_nexys);
      if (CS !== 1'b1 || SCLK !== 1'b1) bad++;
    end
    chk("disabled_idle", 64'(bad), 64'(0));

    // Basic directed frame
    use_fixed = 1'b1;
    enable = 1'b1;
    wait_for(1'b0, 1'b0, SDIV + 5, "basic_cs_fall", n);
    chk("first_tick_latency", 64'(n), 64'(SDIV));
    rises = 0; n = 0; prev_sclk = SCLK;
    while (valid !== 1'b1 && n < 200) begin
      @(negedge clk_nexys);
      n++;
      if (SCLK === 1'b1 && prev_sclk === 1'b0) rises++;
      prev_sclk = SCLK;
    end
    chk("basic_latency", 64'(n), 64'(CS_LOW));
    chk("basic_rises", 64'(rises), 64'(FB));
    chk("basic_dout", 64'(d_out), 64'(EXP_BASIC));
    chk("basic_cs_high", 64'(CS), 64'(1'b1));
    use_fixed = 1'b0;
    @(negedge clk_nexys);
    chk("basic_valid_pulse", 64'(valid), 64'(1'b0));

    // Rate: random frames over 1000 cycles
    falls = 0; sclk_bad = 0; last_fall = -1; low_cnt = 0; prev_cs = CS;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_nexys);
      if (CS === 1'b0 && prev_cs === 1'b1) begin
        if (last_fall >= 0) chk("rate_spacing", 64'(i - last_fall), 64'(SDIV));
        last_fall = i;
        falls++;
        low_cnt = 0;
      end
      if (CS === 1'b0) low_cnt++;
      if (CS === 1'b1 && prev_cs === 1'b0 && last_fall >= 0)
        chk("rate_cs_low", 64'(low_cnt), 64'(CS_LOW));
      if (CS === 1'b1 && SCLK !== 1'b1) sclk_bad++;
      if (valid === 1'b1) chk("rate_dout", 64'(d_out), 64'(cur_exp));
      prev_cs = CS;
    end
    chk("rate_falls", 64'(falls), 64'(10));
    chk("rate_sclk_idle", 64'(sclk_bad), 64'(0));

    // Handshake in the same cycle a new frame completes
    ready = 1'b0;
    wait_for(1'b1, 1'b1, SDIV + 80, "hs_a_valid", n);
    held = cur_exp;
    chk("hs_a_dout", 64'(d_out), 64'(held));
    wait_cs_fall("hs_b_cs");
    repeat (CS_LOW - 1) @(negedge clk_nexys);
    ready = 1'b1;
    @(negedge clk_nexys);
    chk("hs_same_valid", 64'(valid), 64'(1'b1));
    chk("hs_same_dout", 64'(d_out), 64'(cur_exp));
    chk("hs_same_overrun", 64'(overrun), 64'(1'b0));
    @(negedge clk_nexys);
    chk("hs_same_drop", 64'(valid), 64'(1'b0));

    // Backpressure over two frames
    ready = 1'b0;
    wait_for(1'b1, 1'b1, SDIV + 80, "bp_a_valid", n);
    held = cur_exp;
    chk("bp_a_dout", 64'(d_out), 64'(held));
    chk("bp_overrun_clear", 64'(overrun), 64'(1'b0));
    wait_cs_fall("bp_b_cs");
    wait_for(1'b0, 1'b1, CS_LOW + 5, "bp_b_done", n);
    chk("bp_valid_held", 64'(valid), 64'(1'b1));
    chk("bp_dout_held", 64'(d_out), 64'(held));
    chk("bp_overrun_set", 64'(overrun), 64'(1'b1));
    ready = 1'b1;
    @(negedge clk_nexys);
    chk("bp_release_valid", 64'(valid), 64'(1'b0));
    chk("bp_release_dout", 64'(d_out), 64'(held));
    chk("bp_overrun_sticky", 64'(overrun), 64'(1'b1));

    // Enable dropped mid-frame
    wait_cs_fall("en_cs");
    repeat (10) @(negedge clk_nexys);
    enable = 1'b0;
    wait_for(1'b1, 1'b1, SDIV, "en_valid", n);
    chk("en_latency", 64'(n), 64'(CS_LOW - 10));
    chk("en_dout", 64'(d_out), 64'(cur_exp));
    bad = 0;
    repeat (300) begin
      @(negedge clk_nexys);
      if (CS !== 1'b1 || SCLK !== 1'b1) bad++;
    end
    chk("en_no_activity", 64'(bad), 64'(0));

    // Reset 30 cycles into a frame
    enable = 1'b1;
    wait_cs_fall("rst_cs_fall");
    repeat (30) @(negedge clk_nexys);
    reset = 1'b0;
    #1;
    chk("rstmid_cs", 64'(CS), 64'(1'b1));
    chk("rstmid_sclk", 64'(SCLK), 64'(1'b1));
    chk("rstmid_valid", 64'(valid), 64'(1'b0));
    chk("rstmid_dout", 64'(d_out), 64'(0));
    chk("rstmid_overrun", 64'(overrun), 64'(1'b0));
    @(negedge clk_nexys);
    reset = 1'b1;
    bad = 0; first = -1;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk_nexys);
      if (valid !== 1'b0 || d_out !== '0) bad++;
      if (CS === 1'b0 && first < 0) first = i;
    end
    chk("rstmid_no_load", 64'(bad), 64'(0));
    chk("rstmid_restart", 64'(first), 64'(SDIV));
    wait_for(1'b1, 1'b1, SDIV, "rstmid_recover", n);
    chk("rstmid_recover_dout", 64'(d_out), 64'(cur_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
